// File: rtl/ad5601_writer.sv
// Parallel write controller for NUMDACS AD5601 DACs sharing SYNC/SCLK, one DIN per DAC.
// Each request becomes a 16-bit frame {PD1:PD0, code, 6'b0}, shifted MSB first into every DAC at once.
module ad5601_writer #(
    parameter int SYSCLK_FREQ = 100_000_000,
    parameter int SPI_FREQ    = 10_000_000,
    parameter int NUMDACS     = 4
) (
    input  logic                    sclk,
    input  logic                    rstn,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [NUMDACS-1:0][7:0] inData,
    input  logic [1:0]              pdMode,
    output logic                    done,
    output logic                    sync,
    output logic                    dclk,
    output logic [NUMDACS-1:0]      din,
    output logic [1:0]              state_dbg
);

    localparam int CLKDIV = SYSCLK_FREQ / (2 * SPI_FREQ);
    localparam int DW     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    if (CLKDIV < 1) begin : g_bad_clkdiv
        $fatal(1, "ad5601_writer: SPI_FREQ too high for SYSCLK_FREQ (CLKDIV < 1)");
    end
    if (SPI_FREQ > 30_000_000) begin : g_bad_spi_freq
        $fatal(1, "ad5601_writer: SPI_FREQ exceeds the 30 MHz AD5601 limit");
    end

    // Handshake: a request is taken on any sclk edge where inValid && inReady;
    // inReady is high only in IDLE and inValid outside IDLE is dropped, never queued.
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

    state_t                    state, state_next;
    logic [DW-1:0]             div_cnt, div_next;
    logic [3:0]                bit_cnt, bit_next;
    logic                      phase, phase_next;   // 0 = dclk low half, 1 = dclk high half
    logic [NUMDACS-1:0][15:0]  shreg, shreg_next;
    logic                      sync_next, dclk_next, done_next;
    logic                      div_last;

    assign div_last  = (div_cnt == DIV_LAST);
    assign inReady   = (state == IDLE);
    assign state_dbg = state;

    always_comb begin
        for (int i = 0; i < NUMDACS; i++) begin
            din[i] = shreg[i][15];
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            shreg   <= '0;
            sync    <= 1'b1;
            dclk    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            bit_cnt <= bit_next;
            phase   <= phase_next;
            shreg   <= shreg_next;
            sync    <= sync_next;
            dclk    <= dclk_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inValid) state_next = SETUP;
            SETUP:   if (div_last) state_next = SHIFT;
            SHIFT:   if (div_last && phase && (bit_cnt == 4'd15)) state_next = GAP;
            GAP:     if (div_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Computes the next value of every registered output and counter, so the
    // pins never see a combinational path from the inputs.
    always_comb begin
        div_next   = '0;
        bit_next   = bit_cnt;
        phase_next = phase;
        shreg_next = shreg;
        if ((state != IDLE) && !div_last) begin
            div_next = div_cnt + DW'(1);
        end
        case (state)
            IDLE: begin
                bit_next   = '0;
                phase_next = 1'b0;
                if (inValid) begin
                    for (int i = 0; i < NUMDACS; i++) begin
                        shreg_next[i] = {pdMode, inData[i], 6'b000000};
                    end
                end
            end
            SHIFT: begin
                if (div_last) begin
                    phase_next = ~phase;
                    // The next bit appears on the rising dclk, half a period before the DAC samples it.
                    if (!phase) begin
                        for (int i = 0; i < NUMDACS; i++) begin
                            shreg_next[i] = {shreg[i][14:0], 1'b0};
                        end
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase
        sync_next = !((state_next == SETUP) || (state_next == SHIFT));
        dclk_next = !((state_next == SHIFT) && !phase_next);
        done_next = (state_next == GAP) && (div_next == DIV_LAST);
    end

endmodule
